// File: rtl/pipe_stage_skid_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_if
// Purpose : one valid/ready pipeline channel carrying a pipeline slot
//           (payload, PC, exception code, branch-delay flag).
// Signals :
//   valid  producer -> consumer  slot valid
//   ready  consumer -> producer  consumer can accept
//   data   producer -> consumer  payload (DATA_W bits)
//   pc     producer -> consumer  PC of the slot
//   exc    producer -> consumer  exception code, 0 = none (EXC_W bits)
//   bd     producer -> consumer  slot sits in a branch delay slot
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface pipe_stage_skid_if #(
   parameter int DATA_W = 128,
   parameter int EXC_W  = 5
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [31:0]       pc;
   logic [EXC_W-1:0]  exc;
   logic              bd;

   modport master (output valid, data, pc, exc, bd, input  ready);
   modport slave  (input  valid, data, pc, exc, bd, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Purpose : generic pipeline-stage register with a valid/ready handshake and a
//           2-entry skid buffer (main output register + one overflow register).
//           Merges a locally detected exception on capture, supports a flush
//           that leaves a bubble carrying a chosen PC/BD, and counts stall
//           cycles with a saturating counter.
// Ports   :
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_if      upstream channel (slave): valid/data/pc/exc/bd in, ready out
//              (ready is a flop, low only while both entries are occupied)
//   out_if     downstream channel (master): valid/data/pc/exc/bd out, ready in
//   local_exc  exception raised at this boundary, used when upstream has none
//   flush      kill every held slot; wins over accept/emit in the same cycle
//   flush_pc   PC shown on the bubble that follows a flush
//   flush_bd   BD flag shown on the bubble that follows a flush
//   stall_cnt  cycles with out valid & !out ready, saturating
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int          DATA_W   = 128,
   parameter int          EXC_W    = 5,
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   pipe_stage_skid_if.slave  in_if,
   pipe_stage_skid_if.master out_if,
   input  logic [EXC_W-1:0]  local_exc,
   input  logic              flush,
   input  logic [31:0]       flush_pc,
   input  logic              flush_bd,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,  // nothing held, bubble on the output
      ST_ONE   = 2'd1,  // main register holds the output slot
      ST_TWO   = 2'd2   // main and skid both full, upstream blocked
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [31:0]       pc;
      logic [EXC_W-1:0]  exc;
      logic              bd;
   } slot_t;

   state_e           state_q, state_d;
   slot_t            main_q, main_d;
   slot_t            skid_q;
   slot_t            in_slot;
   logic             skid_load;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             out_valid;
   logic             accept;
   logic             emit;

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_if.valid & in_ready_q;
   assign emit      = out_valid & out_if.ready;

   // Incoming slot with the exception merge applied: an upstream code always
   // wins over one raised at this boundary.
   always_comb begin
      in_slot.data = in_if.data;
      in_slot.pc   = in_if.pc;
      in_slot.exc  = (in_if.exc != '0) ? in_if.exc : local_exc;
      in_slot.bd   = in_if.bd;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can infer a latch.
      state_d   = state_q;
      main_d    = main_q;
      skid_load = 1'b0;

      if (flush) begin
         state_d     = ST_EMPTY;
         main_d.data = '0;
         main_d.pc   = flush_pc;
         main_d.exc  = '0;
         main_d.bd   = flush_bd;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  main_d  = in_slot;
               end
            end
            ST_ONE: begin
               if (accept && emit) begin
                  main_d = in_slot;
               end else if (accept) begin
                  state_d   = ST_TWO;
                  skid_load = 1'b1;
               end else if (emit) begin
                  // Bubble: payload and exception clear, PC/BD stay for EPC use.
                  state_d     = ST_EMPTY;
                  main_d.data = '0;
                  main_d.exc  = '0;
               end
            end
            ST_TWO: begin
               if (emit) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end

      // Registered ready: computed from the next state so it is low exactly
      // while the skid holds a slot, with no path from out_if.ready.
      in_ready_d = (state_d != ST_TWO);

      stall_d = stall_q;
      if (out_valid && !out_if.ready && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_q.data <= '0;
         main_q.pc   <= PC_RESET;
         main_q.exc  <= '0;
         main_q.bd   <= 1'b0;
         in_ready_q  <= 1'b1;
         stall_q     <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         in_ready_q <= in_ready_d;
         stall_q    <= stall_d;
      end
   end

   // NOTE: the skid register needs no reset; it is only read in ST_TWO, which is entered only when it is loaded.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_q <= in_slot;
      end
   end

   assign in_if.ready  = in_ready_q;
   assign out_if.valid = out_valid;
   assign out_if.data  = main_q.data;
   assign out_if.pc    = main_q.pc;
   assign out_if.exc   = main_q.exc;
   assign out_if.bd    = main_q.bd;
   assign stall_cnt    = stall_q;

endmodule
